// File: rtl/instr_encoder.sv
// instr_encoder: converts a stream of mnemonic/operand items into machine-code
// words and writes them to consecutive instruction-memory addresses.
// One job = `count` words, starting at `base_addr`. The job begins on a `start`
// pulse.
// An illegal mnemonic aborts the job and sets a sticky error flag.
// Optional feature: define INSTR_ENC_CHECKSUM_EN to get a running XOR
// checksum of the written words. When it is undefined, checksum is tied to 0.
module instr_encoder #(
  parameter int AW        = 8,
  parameter int MCODEBITS = 9
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 start,
  input  logic [AW-1:0]        base_addr,
  input  logic [AW-1:0]        count,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [3:0]           in_mnem,
  input  logic [5:0]           in_operand,
  output logic                 wr_en,
  output logic [AW-1:0]        wr_addr,
  output logic [MCODEBITS-1:0] wr_data,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [MCODEBITS-1:0] checksum
);

  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, ERR = 2'd2} state_t;

  state_t                 r_state;
  logic [AW-1:0]          r_addr;
  logic [AW-1:0]          r_remain;
  logic                   r_wr_en;
  logic [AW-1:0]          r_wr_addr;
  logic [MCODEBITS-1:0]   r_wr_data;
  logic                   r_done;
  logic                   r_err;

  logic                   w_ready;
  logic                   w_accept;
  logic                   w_illegal;
  logic                   w_start;
  logic [8:0]             w_enc9;
  logic [MCODEBITS-1:0]   w_enc;

  // Opcode in [8:6]; ALU-like groups carry a funct in [5:4] and a 4-bit operand
  function automatic logic [8:0] encode(input logic [3:0] m, input logic [5:0] op);
    logic [8:0] word;
    case (m)
      4'd0:    word = {3'b000, 2'b00, op[3:0]};
      4'd1:    word = {3'b000, 2'b01, op[3:0]};
      4'd2:    word = {3'b001, op};
      4'd3:    word = {3'b010, op};
      4'd4:    word = {3'b011, op};
      4'd5:    word = {3'b100, op};
      4'd6:    word = {3'b101, op};
      4'd7:    word = {3'b110, 2'b00, op[3:0]};
      4'd8:    word = {3'b110, 2'b01, op[3:0]};
      4'd9:    word = {3'b110, 2'b10, op[3:0]};
      4'd10:   word = {3'b110, 2'b11, op[3:0]};
      4'd11:   word = {3'b111, 2'b00, op[3:0]};
      4'd12:   word = {3'b111, 2'b01, op[3:0]};
      4'd13:   word = {3'b111, 2'b10, op[3:0]};
      default: word = 9'd0;
    endcase
    return word;
  endfunction

  // in_ready is a pure state decode so a stale in_valid in IDLE is never taken
  assign w_ready   = (r_state == LOAD);
  assign w_accept  = in_valid & w_ready;
  assign w_illegal = (in_mnem > 4'd13);
  assign w_start   = start & (r_state != LOAD);
  assign w_enc9    = encode(in_mnem, in_operand);
  assign w_enc     = MCODEBITS'(w_enc9);

  // Job control FSM with registered write port, done pulse and sticky error.
  // Reset also clears the output register, so a pending write is dropped.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_state   <= IDLE;
      r_addr    <= '0;
      r_remain  <= '0;
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_wr_en <= 1'b0;
      r_done  <= 1'b0;
      case (r_state)
        IDLE, ERR: begin
          if (start) begin
            r_state  <= LOAD;
            r_addr   <= base_addr;
            r_remain <= count;
            r_err    <= 1'b0;
          end
        end
        LOAD: begin
          if (w_accept) begin
            if (w_illegal) begin
              r_state <= ERR;
              r_err   <= 1'b1;
            end else begin
              r_wr_en   <= 1'b1;
              r_wr_addr <= r_addr;
              r_wr_data <= w_enc;
              r_addr    <= r_addr + AW'(1);
              // count==0 loads 0 and wraps, giving 2^AW words before remain==1
              r_remain  <= r_remain - AW'(1);
              if (r_remain == AW'(1)) begin
                r_state <= IDLE;
                r_done  <= 1'b1;
              end
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef INSTR_ENC_CHECKSUM_EN
  logic [MCODEBITS-1:0] r_checksum;

  // Running XOR of issued words; a new job clears it, and it holds after done
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_checksum <= '0;
    end else if (w_start) begin
      r_checksum <= '0;
    end else if (r_wr_en) begin
      r_checksum <= r_checksum ^ r_wr_data;
    end
  end

  assign checksum = r_checksum;
`else
  assign checksum = '0;
`endif

  assign in_ready = w_ready;
  assign busy     = w_ready;
  assign wr_en    = r_wr_en;
  assign wr_addr  = r_wr_addr;
  assign wr_data  = r_wr_data;
  assign done     = r_done;
  assign err      = r_err;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed testbench for instr_encoder with hand-computed expected words.
module tb_instr_encoder;

  logic       Clk;
  logic       Reset;
  logic       start;
  logic [7:0] base_addr;
  logic [7:0] count;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_mnem;
  logic [5:0] in_operand;
  logic       wr_en;
  logic [7:0] wr_addr;
  logic [8:0] wr_data;
  logic       busy;
  logic       done;
  logic       err;
  logic [8:0] checksum;

  int n_chk = 0;
  int n_err = 0;
  int n_wr  = 0;
  int wr_mark;

  instr_encoder #(.AW(8), .MCODEBITS(9)) dut (
    .Clk(Clk), .Reset(Reset), .start(start), .base_addr(base_addr),
    .count(count), .in_valid(in_valid), .in_ready(in_ready),
    .in_mnem(in_mnem), .in_operand(in_operand), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy), .done(done),
    .err(err), .checksum(checksum)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  always @(negedge Clk) if (wr_en === 1'b1) n_wr++;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic item(input logic [3:0] m, input logic [5:0] op);
    in_valid   = 1'b1;
    in_mnem    = m;
    in_operand = op;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_wr_en"},    32'(wr_en),    0);
    chk({tag, "_wr_addr"},  32'(wr_addr),  0);
    chk({tag, "_wr_data"},  32'(wr_data),  0);
    chk({tag, "_in_ready"}, 32'(in_ready), 0);
    chk({tag, "_busy"},     32'(busy),     0);
    chk({tag, "_done"},     32'(done),     0);
    chk({tag, "_err"},      32'(err),      0);
    chk({tag, "_checksum"}, 32'(checksum), 0);
  endtask

  function automatic logic [8:0] cks(input logic [8:0] v);
`ifdef INSTR_ENC_CHECKSUM_EN
    return v;
`else
    return 9'h000 & v;
`endif
  endfunction

  initial begin
    Reset = 1'b0; start = 1'b0; base_addr = '0; count = '0;
    in_valid = 1'b0; in_mnem = '0; in_operand = '0;
    tick(); tick();
    chk_zero("reset");
    Reset = 1'b1;
    tick();

    // Three-word job at 0x10: add, sub, mul
    start = 1'b1; base_addr = 8'h10; count = 8'd3;
    tick();
    start = 1'b0;
    chk("t1_busy", 32'(busy), 1);
    chk("t1_ready", 32'(in_ready), 1);
    item(4'd0, 6'h05); tick();
    chk("t1_w0_en", 32'(wr_en), 1);
    chk("t1_w0_addr", 32'(wr_addr), 'h10);
    chk("t1_w0_data", 32'(wr_data), 'h005);
    chk("t1_w0_done", 32'(done), 0);
    item(4'd1, 6'h03); tick();
    chk("t1_w1_addr", 32'(wr_addr), 'h11);
    chk("t1_w1_data", 32'(wr_data), 'h013);
    item(4'd13, 6'h0F); tick();
    in_valid = 1'b0;
    chk("t1_w2_en", 32'(wr_en), 1);
    chk("t1_w2_addr", 32'(wr_addr), 'h12);
    chk("t1_w2_data", 32'(wr_data), 'h1EF);
    chk("t1_done", 32'(done), 1);
    chk("t1_busy_fall", 32'(busy), 0);
    chk("t1_ready_fall", 32'(in_ready), 0);
    tick();
    chk("t1_wr_en_end", 32'(wr_en), 0);
    chk("t1_done_end", 32'(done), 0);
    chk("t1_checksum", 32'(checksum), 32'(cks(9'h005 ^ 9'h013 ^ 9'h1EF)));
    tick();
    chk("t1_checksum_hold", 32'(checksum), 32'(cks(9'h005 ^ 9'h013 ^ 9'h1EF)));

    // Address wrap: three mov at 0xFE
    start = 1'b1; base_addr = 8'hFE; count = 8'd3;
    tick();
    start = 1'b0;
    item(4'd6, 6'h2A); tick();
    chk("t2_a0", 32'(wr_addr), 'hFE);
    chk("t2_d0", 32'(wr_data), 'h16A);
    tick();
    chk("t2_a1", 32'(wr_addr), 'hFF);
    chk("t2_d1", 32'(wr_data), 'h16A);
    tick();
    in_valid = 1'b0;
    chk("t2_a2", 32'(wr_addr), 'h00);
    chk("t2_d2", 32'(wr_data), 'h16A);
    chk("t2_done", 32'(done), 1);
    tick();
    chk("t2_checksum", 32'(checksum), 32'(cks(9'h16A)));

    // Illegal mnemonic aborts a four-word job
    start = 1'b1; base_addr = 8'h80; count = 8'd4;
    tick();
    start = 1'b0;
    wr_mark = n_wr;
    item(4'd4, 6'h07); tick();
    chk("t3_imm_addr", 32'(wr_addr), 'h80);
    chk("t3_imm_data", 32'(wr_data), 'h0C7);
    item(4'd15, 6'h01); tick();
    chk("t3_ill_wr_en", 32'(wr_en), 0);
    chk("t3_err", 32'(err), 1);
    chk("t3_ready", 32'(in_ready), 0);
    chk("t3_state", 32'(dut.r_state), 2);
    item(4'd0, 6'h01); tick();
    chk("t3_done_a", 32'(done), 0);
    item(4'd1, 6'h02); tick();
    chk("t3_done_b", 32'(done), 0);
    chk("t3_err_sticky", 32'(err), 1);
    chk("t3_writes", 32'(n_wr - wr_mark), 1);

    // Start from ERR with a stale in_valid still high; then a gap in the stream
    start = 1'b1; base_addr = 8'h40; count = 8'd2;
    item(4'd0, 6'h09);
    tick();
    start = 1'b0;
    chk("t4_err_clr", 32'(err), 0);
    chk("t4_busy", 32'(busy), 1);
    chk("t4_stale_wr_en", 32'(wr_en), 0);
    item(4'd0, 6'h01); tick();
    chk("t4_w0_addr", 32'(wr_addr), 'h40);
    chk("t4_w0_data", 32'(wr_data), 'h001);
    in_valid = 1'b0;
    wr_mark = n_wr;
    tick(); tick(); tick();
    chk("t4_gap_writes", 32'(n_wr - wr_mark), 1);
    chk("t4_gap_ready", 32'(in_ready), 1);
    chk("t4_gap_done", 32'(done), 0);
    item(4'd11, 6'h02); tick();
    in_valid = 1'b0;
    chk("t4_w1_addr", 32'(wr_addr), 'h41);
    chk("t4_w1_data", 32'(wr_data), 'h1C2);
    chk("t4_done", 32'(done), 1);
    tick();

    // Reset right after an acceptance drops the pending write
    start = 1'b1; base_addr = 8'h20; count = 8'd3;
    tick();
    start = 1'b0;
    item(4'd0, 6'h03); tick();
    Reset = 1'b0;
    #1;
    wr_mark = n_wr;
    chk_zero("rst_async");
    tick();
    chk_zero("rst_held");
    chk("rst_no_write", 32'(n_wr - wr_mark), 0);
    in_valid = 1'b0;
    Reset = 1'b1;
    tick();
    start = 1'b1; base_addr = 8'h30; count = 8'd1;
    tick();
    start = 1'b0;
    item(4'd10, 6'h04); tick();
    in_valid = 1'b0;
    chk("t5_wr_en", 32'(wr_en), 1);
    chk("t5_addr", 32'(wr_addr), 'h30);
    chk("t5_data", 32'(wr_data), 'h1B4);
    chk("t5_done", 32'(done), 1);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
